// File: rtl/mccoy_pkg.sv
// Shared types and constants for the McCoy core control path.
// Holds the sequencer state encoding, opcode values and instruction field widths.
package mccoy_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT,
    S_FAULT
  } state_t;

  localparam logic [2:0] OP_BEZ  = 3'd0;
  localparam logic [2:0] OP_LI   = 3'd1;
  localparam logic [2:0] OP_JA   = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_LR   = 3'd4;
  localparam logic [2:0] OP_NOT  = 3'd5;
  localparam logic [2:0] OP_SR   = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  // Opcode occupies the top OPC_W bits of the instruction word.
  localparam int OPC_W = 3;
  // Fetch timeout counter width; supports timeouts up to 2^TO_W-1 cycles.
  localparam int TO_W  = 4;

endpackage

// File: rtl/mccoy_pc.sv
// Program counter register for the McCoy sequencer.
// A load takes priority over an increment; the increment wraps modulo 2^PC_W.
module mccoy_pc
  import mccoy_pkg::*;
#(
  parameter int PC_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= '0;
    end else if (load) begin
      pc_reg <= target;
    end else if (inc) begin
      pc_reg <= pc_reg + 1'b1;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/mccoy_sequencer.sv
// Multi-cycle control FSM of the McCoy core: fetch over req/ack, decode, execute, write back.
// Owns the IR, the fetch timeout counter and the branch decision; the PC lives in mccoy_pc.
module mccoy_sequencer
  import mccoy_pkg::*;
#(
  parameter int PC_W     = 5,
  parameter int IW       = 8,
  parameter int FETCH_TO = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [IW-1:0]   imem_data,
  output logic [2:0]      opcode,
  output logic [PC_W-1:0] operand,
  input  logic            dec_bez,
  input  logic            dec_ja,
  input  logic            dec_wreg,
  input  logic            dec_wx8,
  input  logic            x8_zero,
  output logic            alu_en,
  output logic            reg_we,
  output logic            x8_we,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            fault
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TO - 1);

  state_t          state_reg, state_next;
  logic [IW-1:0]   ir_reg;
  logic [TO_W-1:0] to_cnt_reg;
  logic            taken_reg;
  logic            pc_inc, pc_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      ir_reg     <= '0;
      to_cnt_reg <= '0;
      taken_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_FETCH) begin
        if (imem_ack) begin
          ir_reg     <= imem_data;
          to_cnt_reg <= '0;
        end else if (to_cnt_reg == TO_LAST) begin
          to_cnt_reg <= '0;
        end else begin
          to_cnt_reg <= to_cnt_reg + 1'b1;
        end
      end
      // Branch condition is frozen in EXEC so x8_zero is never looked at elsewhere.
      if (state_reg == S_EXEC) begin
        taken_reg <= (dec_bez & x8_zero) | dec_ja;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    imem_req   = 1'b0;
    alu_en     = 1'b0;
    reg_we     = 1'b0;
    x8_we      = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    case (state_reg)
      S_IDLE, S_HALT, S_FAULT: begin
        if (run) state_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_next = S_DECODE;
        end else if (to_cnt_reg == TO_LAST) begin
          state_next = S_FAULT;
        end
      end
      S_DECODE: begin
        if (opcode == OP_HALT) begin
          pc_inc     = 1'b1;
          state_next = S_HALT;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_en     = 1'b1;
        state_next = S_WB;
      end
      S_WB: begin
        reg_we     = dec_wreg;
        x8_we      = dec_wx8;
        pc_load    = taken_reg;
        pc_inc     = ~taken_reg;
        state_next = S_FETCH;
      end
      default: state_next = S_IDLE;
    endcase
  end

  mccoy_pc #(.PC_W(PC_W)) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (pc_inc),
    .load   (pc_load),
    .target (operand),
    .pc     (pc)
  );

  assign opcode    = ir_reg[IW-1 -: OPC_W];
  assign operand   = ir_reg[PC_W-1:0];
  assign imem_addr = pc;
  assign busy      = (state_reg == S_FETCH) || (state_reg == S_DECODE) ||
                     (state_reg == S_EXEC)  || (state_reg == S_WB);
  assign halted    = (state_reg == S_HALT);
  assign fault     = (state_reg == S_FAULT);

endmodule

// File: tb/tb_mccoy_sequencer.sv
// Directed self-checking bench for mccoy_sequencer with a behavioural program memory and decoder.
// Memory acks ack_lat cycles after a request appears; each accepted fetch prints one line.
module tb_mccoy_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       x8_zero = 1'b0;
  logic       force_ack = 1'b0;
  logic       ack_resp = 1'b0;
  logic       mem_en = 1'b1;
  int         ack_lat = 0;
  int         wait_cnt = 0;
  logic [7:0] mem [32];

  logic       imem_req, imem_ack;
  logic [4:0] imem_addr, operand, pc;
  logic [7:0] imem_data;
  logic [2:0] opcode;
  logic       dec_bez, dec_ja, dec_wreg, dec_wx8;
  logic       alu_en, reg_we, x8_we, busy, halted, fault;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [4:0] fetch_q[$];
  logic [4:0] x8_q[$];
  logic [4:0] reg_q[$];

  always #5 clk = ~clk;

  assign imem_ack  = ack_resp | force_ack;
  assign imem_data = mem[imem_addr];

  // Reference decoder: sr writes the register file; li/add/lr/not write x8.
  assign dec_bez  = (opcode == 3'd0);
  assign dec_ja   = (opcode == 3'd2);
  assign dec_wreg = (opcode == 3'd6);
  assign dec_wx8  = (opcode == 3'd1) || (opcode == 3'd3) || (opcode == 3'd4) || (opcode == 3'd5);

  mccoy_sequencer #(.PC_W(5), .IW(8), .FETCH_TO(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .opcode    (opcode),
    .operand   (operand),
    .dec_bez   (dec_bez),
    .dec_ja    (dec_ja),
    .dec_wreg  (dec_wreg),
    .dec_wx8   (dec_wx8),
    .x8_zero   (x8_zero),
    .alu_en    (alu_en),
    .reg_we    (reg_we),
    .x8_we     (x8_we),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted),
    .fault     (fault)
  );

  always @(negedge clk) begin
    if (mem_en && imem_req && !ack_resp && wait_cnt >= ack_lat) begin
      ack_resp <= 1'b1;
      wait_cnt <= 0;
    end else begin
      ack_resp <= 1'b0;
      if (mem_en && imem_req && !ack_resp) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (imem_req && imem_ack) begin
        fetch_q.push_back(imem_addr);
        $display("fetch  addr=%0d data=%02h t=%0t", imem_addr, imem_data, $time);
      end
      if (x8_we) x8_q.push_back(pc);
      if (reg_we) reg_q.push_back(pc);
    end
  end

  task automatic fill_mem(input logic [7:0] v);
    for (int i = 0; i < 32; i++) mem[i] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    force_ack = 1'b0;
    x8_zero = 1'b0;
    mem_en = 1'b1;
    ack_lat = 0;
    fill_mem(8'hE0);
    repeat (2) @(negedge clk);
    fetch_q.delete();
    x8_q.delete();
    reg_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic pulse_run();
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_fetch(output logic [4:0] a, output bit ok);
    a = '0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fetch_q.size() > 0) begin
        a = fetch_q.pop_front();
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total_cnt++;
    if ({imem_req, busy, halted, fault, alu_en, reg_we, x8_we} !== 7'b0 ||
        pc !== 5'd0 || opcode !== 3'd0 || operand !== 5'd0)
      $display("FAIL reset_state: req=%b busy=%b halted=%b fault=%b alu=%b rwe=%b xwe=%b pc=%0d op=%0d opd=%0d, required all zero",
               imem_req, busy, halted, fault, alu_en, reg_we, x8_we, pc, opcode, operand);
    else pass_cnt++;
  endtask

  task automatic test_program();
    logic h10, h11, b10;
    int alu_cnt;
    logic [4:0] a;
    bit ok;
    alu_cnt = 0;
    h10 = 1'b0; h11 = 1'b0; b10 = 1'b0;
    do_reset();
    mem[0] = 8'h23;  // li 3
    mem[1] = 8'h60;  // add
    mem[2] = 8'hE0;  // halt
    @(negedge clk);
    run = 1'b1;
    // Edge 1 samples run; three 4-cycle slots minus EXEC/WB of halt put HALT after edge 11.
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) run = 1'b0;
      if (alu_en) alu_cnt++;
      if (k == 10) begin h10 = halted; b10 = busy; end
      if (k == 11) h11 = halted;
    end
    total_cnt++;
    if (h10 !== 1'b0 || b10 !== 1'b1 || h11 !== 1'b1)
      $display("FAIL halt_timing: halted@10=%b busy@10=%b halted@11=%b, required 0 1 1", h10, b10, h11);
    else pass_cnt++;
    total_cnt++;
    if (fetch_q.size() != 3 || fetch_q[0] !== 5'd0 || fetch_q[1] !== 5'd1 || fetch_q[2] !== 5'd2)
      $display("FAIL prog_addrs: got %p, required '{0,1,2}", fetch_q);
    else pass_cnt++;
    total_cnt++;
    if (pc !== 5'd3) $display("FAIL halt_pc: pc=%0d, required 3", pc);
    else pass_cnt++;
    total_cnt++;
    if (x8_q.size() != 2 || x8_q[0] !== 5'd0 || x8_q[1] !== 5'd1 || reg_q.size() != 0 || alu_cnt != 2)
      $display("FAIL prog_strobes: x8_we at %p reg_we at %p alu cycles %0d, required x8 '{0,1} reg none alu 2",
               x8_q, reg_q, alu_cnt);
    else pass_cnt++;
    fetch_q.delete();
    pulse_run();
    wait_fetch(a, ok);
    total_cnt++;
    if (!ok || a !== 5'd3 || halted !== 1'b0)
      $display("FAIL resume_after_halt: ok=%b addr=%0d halted=%b, required addr 3 halted 0", ok, a, halted);
    else pass_cnt++;
  endtask

  task automatic test_bez();
    logic [4:0] a;
    bit ok;
    do_reset();
    mem[0] = 8'h05;  // bez 5
    mem[5] = 8'h05;
    x8_zero = 1'b1;
    pulse_run();
    wait_fetch(a, ok);
    wait_fetch(a, ok);
    total_cnt++;
    if (!ok || a !== 5'd5) $display("FAIL bez_taken: ok=%b addr=%0d, required 5", ok, a);
    else pass_cnt++;
    x8_zero = 1'b0;
    wait_fetch(a, ok);
    total_cnt++;
    if (!ok || a !== 5'd6) $display("FAIL bez_not_taken: ok=%b addr=%0d, required 6", ok, a);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [4:0] a;
    bit ok;
    do_reset();
    mem[0]  = 8'h5F;  // ja 31
    mem[31] = 8'h40;  // ja 0
    pulse_run();
    wait_fetch(a, ok);
    wait_fetch(a, ok);
    total_cnt++;
    if (!ok || a !== 5'd31) $display("FAIL ja_31: ok=%b addr=%0d, required 31", ok, a);
    else pass_cnt++;
    wait_fetch(a, ok);
    total_cnt++;
    if (!ok || a !== 5'd0) $display("FAIL ja_0_at_31: ok=%b addr=%0d, required 0", ok, a);
    else pass_cnt++;
    do_reset();
    mem[0]  = 8'h5F;
    mem[31] = 8'h60;  // add
    pulse_run();
    wait_fetch(a, ok);
    wait_fetch(a, ok);
    wait_fetch(a, ok);
    total_cnt++;
    if (!ok || a !== 5'd0) $display("FAIL pc_wrap: ok=%b addr=%0d, required 0", ok, a);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    logic [4:0] a;
    bit ok, got_fault;
    int req_cycles;
    req_cycles = 0;
    got_fault = 1'b0;
    do_reset();
    mem[0] = 8'h60;
    pulse_run();
    wait_fetch(a, ok);
    mem_en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (imem_req) req_cycles++;
      if (fault) begin got_fault = 1'b1; break; end
    end
    total_cnt++;
    if (!got_fault || req_cycles != 15)
      $display("FAIL fetch_timeout: fault=%b fetch cycles=%0d, required fault after 15", got_fault, req_cycles);
    else pass_cnt++;
    total_cnt++;
    if (imem_req !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 || pc !== 5'd1)
      $display("FAIL fault_state: req=%b busy=%b halted=%b pc=%0d, required 0 0 0 pc 1", imem_req, busy, halted, pc);
    else pass_cnt++;
    mem_en = 1'b1;
    pulse_run();
    total_cnt++;
    if (fault !== 1'b0 || busy !== 1'b1) $display("FAIL fault_clear: fault=%b busy=%b, required 0 1", fault, busy);
    else pass_cnt++;
    wait_fetch(a, ok);
    total_cnt++;
    if (!ok || a !== 5'd1) $display("FAIL refetch: ok=%b addr=%0d, required 1", ok, a);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [4:0] a;
    bit ok, saw_req;
    saw_req = 1'b0;
    do_reset();
    mem[0] = 8'h60;
    pulse_run();
    wait_fetch(a, ok);
    ack_lat = 3;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req) begin saw_req = 1'b1; break; end
    end
    @(negedge clk);
    total_cnt++;
    if (!saw_req || imem_req !== 1'b1 || pc !== 5'd1)
      $display("FAIL pre_reset_fetch: saw=%b req=%b pc=%0d, required req 1 pc 1", saw_req, imem_req, pc);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (imem_req !== 1'b0 || busy !== 1'b0 || pc !== 5'd0 || reg_we !== 1'b0 || x8_we !== 1'b0)
      $display("FAIL async_reset: req=%b busy=%b pc=%0d rwe=%b xwe=%b, required all 0", imem_req, busy, pc, reg_we, x8_we);
    else pass_cnt++;
    mem_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || imem_req !== 1'b0 || opcode !== 3'd0 || fetch_q.size() != 0)
      $display("FAIL late_ack: busy=%b req=%b opcode=%0d fetches=%0d, required idle, opcode 0, none",
               busy, imem_req, opcode, fetch_q.size());
    else pass_cnt++;
    mem_en = 1'b1;
    ack_lat = 0;
    pulse_run();
    wait_fetch(a, ok);
    total_cnt++;
    if (!ok || a !== 5'd0) $display("FAIL post_reset_fetch: ok=%b addr=%0d, required 0", ok, a);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit got_halt;
    int idle_gaps;
    got_halt = 1'b0;
    idle_gaps = 0;
    do_reset();
    mem[0] = 8'hC1;  // sr 1
    mem[1] = 8'h82;  // lr 2
    ack_lat = 2;
    @(negedge clk);
    run = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (halted) begin got_halt = 1'b1; break; end
      if (!busy) idle_gaps++;
    end
    run = 1'b0;
    total_cnt++;
    if (!got_halt || idle_gaps != 0)
      $display("FAIL busy_hold: halted=%b non-busy cycles=%0d, required halted with 0", got_halt, idle_gaps);
    else pass_cnt++;
    total_cnt++;
    if (reg_q.size() != 1 || reg_q[0] !== 5'd0 || x8_q.size() != 1 || x8_q[0] !== 5'd1)
      $display("FAIL sr_lr_strobes: reg_we at %p x8_we at %p, required reg '{0} x8 '{1}", reg_q, x8_q);
    else pass_cnt++;
    total_cnt++;
    if (fetch_q.size() != 3 || fetch_q[0] !== 5'd0 || fetch_q[1] !== 5'd1 || fetch_q[2] !== 5'd2)
      $display("FAIL latency_addrs: got %p, required '{0,1,2}", fetch_q);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (halted !== 1'b1 || busy !== 1'b0 || pc !== 5'd3)
      $display("FAIL halt_hold: halted=%b busy=%b pc=%0d, required 1 0 3", halted, busy, pc);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_program();
    test_bez();
    test_wrap();
    test_timeout();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
